wt_dispatch: RTL and testbench

Reads kernel weights out of the weight buffer and delivers them to the PE matrix as mode-tagged segments over a valid/ready handshake. It is the consumer of the weight buffer, the opposite end of the DDR-side weight loader that fills it. A 5×5 kernel group is emitted as four segments, A(9) then B(6) then C(6) then D(4) positions. A 3×3 kernel group is emitted as one E(9) segment.

---
 rtl/diff_core_pkg.sv | 47 ++++
 rtl/wt_seg_assembler.sv | 38 +++
 rtl/wt_dispatch.sv | 154 +++++++++++++++
 tb/tb_wt_dispatch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_core_pkg.sv
// Shared types and constants for the weight path: PE weight modes,
// segment lengths, buffer geometry and the dispatch FSM state encoding.
package diff_core_pkg;

   localparam int CONF_BIT_WIDTH    = 8;
   localparam int CONF_LANES        = 8;
   localparam int CONF_WT_BUF_DEPTH = 512;

   typedef enum logic [2:0] {
      A_MODE = 3'd0,
      B_MODE = 3'd1,
      C_MODE = 3'd2,
      D_MODE = 3'd3,
      E_MODE = 3'd4
   } PE_weight_mode_t;

   // Number of weight positions carried by each segment kind.
   localparam int SEG_LEN_A = 9;
   localparam int SEG_LEN_B = 6;
   localparam int SEG_LEN_C = 6;
   localparam int SEG_LEN_D = 4;
   localparam int SEG_LEN_E = 9;

   // Widest segment; the slot register file is sized for it.
   localparam int SEG_SLOTS = 9;

   typedef logic [CONF_LANES-1:0][CONF_BIT_WIDTH-1:0] wt_word_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      WAIT_DATA = 3'd2,
      OFFER     = 3'd3,
      FINISH    = 3'd4
   } wt_disp_state_t;

   function automatic logic [3:0] seg_len(input PE_weight_mode_t mode);
      case (mode)
         A_MODE:  seg_len = 4'(SEG_LEN_A);
         B_MODE:  seg_len = 4'(SEG_LEN_B);
         C_MODE:  seg_len = 4'(SEG_LEN_C);
         D_MODE:  seg_len = 4'(SEG_LEN_D);
         default: seg_len = 4'(SEG_LEN_E);
      endcase
   endfunction

endpackage

// File: rtl/wt_seg_assembler.sv
// Slot register file for one outgoing segment. Words returned by the
// weight buffer are written into their slot; a clear at the start of each
// segment fetch zeroes every slot so positions beyond the segment length
// read as 0.
module wt_seg_assembler
   import diff_core_pkg::*;
#(
   parameter int WORD_W = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        cap_en,
   input  logic [3:0]                  cap_slot,
   input  logic [WORD_W-1:0]           cap_data,
   output logic [SEG_SLOTS*WORD_W-1:0] seg
);

   logic [WORD_W-1:0] slot_q [SEG_SLOTS];

   // Clear on segment start, otherwise capture the returned word into its slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SEG_SLOTS; i++) slot_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < SEG_SLOTS; i++) slot_q[i] <= '0;
      end else if (cap_en && (cap_slot < 4'(SEG_SLOTS))) begin
         slot_q[cap_slot] <= cap_data;
      end
   end

   // Flatten the slots onto the segment bus, position p at bits [p*WORD_W +: WORD_W].
   always_comb begin
      seg = '0;
      for (int p = 0; p < SEG_SLOTS; p++) seg[p*WORD_W +: WORD_W] = slot_q[p];
   end

endmodule

// File: rtl/wt_dispatch.sv
// Weight dispatcher: reads kernel weights out of the weight buffer and
// offers them to the PE matrix as mode-tagged segments. A 5x5 group is sent
// as A,B,C,D segments, a 3x3 group as one E segment. The read pointer runs
// contiguously across segments and groups and wraps at the buffer depth.
//
// Handshake: wt_valid rises only when a complete segment is assembled;
// while wt_valid is high, wt_seg and wt_mode hold steady until a cycle with
// wt_valid && wt_ready, which is the single transfer. wt_ready without
// wt_valid is ignored. All outputs come from flops.
module wt_dispatch
   import diff_core_pkg::*;
#(
   parameter  int BIT_WIDTH    = CONF_BIT_WIDTH,
   parameter  int LANES        = CONF_LANES,
   parameter  int WT_BUF_DEPTH = CONF_WT_BUF_DEPTH,
   localparam int ADDR_W       = $clog2(WT_BUF_DEPTH),
   localparam int WORD_W       = LANES * BIT_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        kernel_mode,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [8:0]                  num_kernels,
   output logic                        busy,
   output logic                        done,
   output logic                        wt_rd_en,
   output logic [ADDR_W-1:0]           wt_rd_addr,
   input  logic [WORD_W-1:0]           wt_rd_data,
   output logic [SEG_SLOTS*WORD_W-1:0] wt_seg,
   output PE_weight_mode_t             wt_mode,
   output logic                        wt_valid,
   input  logic                        wt_ready,
   output logic [2:0]                  dbg_state
);

   wt_disp_state_t  state_q, state_d;
   logic            kmode_q;
   logic [8:0]      groups_q;
   logic [3:0]      fetch_cnt_q;
   logic            cap_en_q;
   logic [3:0]      cap_slot_q;
   logic            last_fetch;
   logic            last_seg;
   logic            last_group;
   logic            seg_clear;
   logic [ADDR_W-1:0] next_ptr;
   PE_weight_mode_t next_mode;

   assign dbg_state  = state_q;
   assign last_fetch = (fetch_cnt_q == (seg_len(wt_mode) - 4'd1));
   assign last_seg   = (wt_mode == D_MODE) || (wt_mode == E_MODE);
   assign last_group = (groups_q == 9'd1);
   // Every entry into FETCH starts a fresh segment with all slots zeroed.
   assign seg_clear  = (state_d == FETCH) && (state_q != FETCH);
   assign next_ptr   = (wt_rd_addr == ADDR_W'(WT_BUF_DEPTH - 1)) ? '0 : wt_rd_addr + 1'b1;

   // Segment order within a group: A,B,C,D for 5x5, always E for 3x3.
   always_comb begin
      next_mode = E_MODE;
      if (kmode_q) begin
         case (wt_mode)
            A_MODE:  next_mode = B_MODE;
            B_MODE:  next_mode = C_MODE;
            C_MODE:  next_mode = D_MODE;
            default: next_mode = A_MODE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start) state_d = (num_kernels != 9'd0) ? FETCH : FINISH;
         FETCH:     if (last_fetch) state_d = WAIT_DATA;
         WAIT_DATA: state_d = OFFER;
         OFFER:     if (wt_ready) state_d = (last_seg && last_group) ? FINISH : FETCH;
         FINISH:    state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Status and handshake outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         wt_rd_en <= 1'b0;
         wt_valid <= 1'b0;
      end else begin
         busy     <= (state_d == FETCH) || (state_d == WAIT_DATA) || (state_d == OFFER);
         done     <= (state_d == FINISH);
         wt_rd_en <= (state_d == FETCH);
         wt_valid <= (state_d == OFFER);
      end
   end

   // Command latch, read pointer, segment/group bookkeeping and capture delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kmode_q     <= 1'b0;
         groups_q    <= '0;
         wt_mode     <= A_MODE;
         fetch_cnt_q <= '0;
         wt_rd_addr  <= '0;
         cap_en_q    <= 1'b0;
         cap_slot_q  <= '0;
      end else begin
         // Read data returns one cycle after the read, so slot follows by one.
         cap_en_q   <= wt_rd_en;
         cap_slot_q <= fetch_cnt_q;
         case (state_q)
            IDLE: begin
               if (start && (num_kernels != 9'd0)) begin
                  kmode_q     <= kernel_mode;
                  groups_q    <= num_kernels;
                  wt_mode     <= kernel_mode ? A_MODE : E_MODE;
                  wt_rd_addr  <= base_addr;
                  fetch_cnt_q <= '0;
               end
            end
            FETCH: begin
               wt_rd_addr  <= next_ptr;
               fetch_cnt_q <= last_fetch ? 4'd0 : fetch_cnt_q + 4'd1;
            end
            OFFER: begin
               if (wt_ready) begin
                  wt_mode <= next_mode;
                  if (last_seg) groups_q <= groups_q - 9'd1;
               end
            end
            default: ;
         endcase
      end
   end

   wt_seg_assembler #(.WORD_W(WORD_W)) u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (seg_clear),
      .cap_en   (cap_en_q),
      .cap_slot (cap_slot_q),
      .cap_data (wt_rd_data),
      .seg      (wt_seg)
   );

endmodule

// File: tb/tb_wt_dispatch.sv
// Bench for wt_dispatch: table of whole-command runs with hand-computed
// latencies and counts, segment contents from a buffer model, plus directed
// sequences for ready stalls and mid-fetch reset.
module tb_wt_dispatch;
   import diff_core_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic            kernel_mode;
   logic [8:0]      base_addr;
   logic [8:0]      num_kernels;
   logic            busy;
   logic            done;
   logic            wt_rd_en;
   logic [8:0]      wt_rd_addr;
   logic [63:0]     wt_rd_data = '0;
   logic [575:0]    wt_seg;
   PE_weight_mode_t wt_mode;
   logic            wt_valid;
   logic            wt_ready;
   logic [2:0]      dbg_state;

   int applied     = 0;
   int miscompares = 0;

   typedef struct {
      logic km;
      int   base;
      int   nk;
      bit   glitch;     // pulse a conflicting start at cycle 5
      int   exp_valid;  // cycle of first wt_valid, -1 if none
      int   exp_done;
      int   exp_segs;
      int   exp_reads;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   wt_dispatch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .kernel_mode (kernel_mode),
      .base_addr   (base_addr),
      .num_kernels (num_kernels),
      .busy        (busy),
      .done        (done),
      .wt_rd_en    (wt_rd_en),
      .wt_rd_addr  (wt_rd_addr),
      .wt_rd_data  (wt_rd_data),
      .wt_seg      (wt_seg),
      .wt_mode     (wt_mode),
      .wt_valid    (wt_valid),
      .wt_ready    (wt_ready),
      .dbg_state   (dbg_state)
   );

   function automatic logic [63:0] word_of(input int a);
      logic [15:0] x;
      x = a[15:0];
      return {x ^ 16'hA5A5, ~x, x + 16'h1234, x};
   endfunction

   // Weight buffer model with one-cycle read latency.
   always @(posedge clk) begin
      if (wt_rd_en) wt_rd_data <= word_of(int'(wt_rd_addr));
   end

   function automatic int tb_len(input logic km, input int seg_i);
      int lens5[4] = '{9, 6, 6, 4};
      return km ? lens5[seg_i % 4] : 9;
   endfunction

   function automatic PE_weight_mode_t tb_mode(input logic km, input int seg_i);
      if (!km) return E_MODE;
      case (seg_i % 4)
         0:       return A_MODE;
         1:       return B_MODE;
         2:       return C_MODE;
         default: return D_MODE;
      endcase
   endfunction

   function automatic logic [575:0] exp_seg_of(input int ptr, input int n);
      logic [575:0] s;
      s = '0;
      for (int p = 0; p < 9; p++)
         if (p < n) s[p*64 +: 64] = word_of((ptr + p) % 512);
      return s;
   endfunction

   task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int c, seg_i, sptr, rptr, reads, first_valid, done_cyc, busy_err, addr_err, n;
      logic exp_busy;
      v = vecs[idx];
      seg_i = 0; sptr = v.base; rptr = v.base; reads = 0;
      first_valid = -1; done_cyc = -1; busy_err = 0; addr_err = 0;
      @(negedge clk);
      start = 1'b1; kernel_mode = v.km; base_addr = 9'(v.base);
      num_kernels = 9'(v.nk); wt_ready = 1'b1;
      c = 0;
      while (done_cyc < 0 && c < 200) begin
         @(negedge clk);
         c++;
         start = 1'b0;
         if (v.glitch && c == 5) begin
            start = 1'b1; kernel_mode = 1'b0; base_addr = 9'd300; num_kernels = 9'd5;
         end
         if (wt_rd_en) begin
            if (int'(wt_rd_addr) != rptr) addr_err++;
            rptr = (rptr + 1) % 512;
            reads++;
         end
         if (wt_valid) begin
            if (first_valid < 0) first_valid = c;
            n = tb_len(v.km, seg_i);
            check($sformatf("v%0d seg%0d data", idx, seg_i), wt_seg, exp_seg_of(sptr, n));
            check($sformatf("v%0d seg%0d mode", idx, seg_i), wt_mode, tb_mode(v.km, seg_i));
            sptr = (sptr + n) % 512;
            seg_i++;
         end
         exp_busy = (v.nk != 0) && !done;
         if (busy !== exp_busy) busy_err++;
         if (done) done_cyc = c;
      end
      start = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d done pulse/idle", idx), {done, busy, wt_valid, dbg_state}, {3'b000, 3'(IDLE)});
      check($sformatf("v%0d first valid cycle", idx), first_valid, v.exp_valid);
      check($sformatf("v%0d done cycle", idx), done_cyc, v.exp_done);
      check($sformatf("v%0d segment count", idx), seg_i, v.exp_segs);
      check($sformatf("v%0d read count", idx), reads, v.exp_reads);
      check($sformatf("v%0d read addr errors", idx), addr_err, 0);
      check($sformatf("v%0d busy errors", idx), busy_err, 0);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int c;
      c = 0;
      while (!wt_valid && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({name, " valid seen"}, wt_valid, 1'b1);
   endtask

   task automatic stall_seq();
      logic [575:0]    s0;
      PE_weight_mode_t m0;
      int stall_err, c;
      @(negedge clk);
      start = 1'b1; kernel_mode = 1'b1; base_addr = 9'd200; num_kernels = 9'd1; wt_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_valid("stall A", 40);
      s0 = wt_seg; m0 = wt_mode;
      check("stall A data", s0, exp_seg_of(200, 9));
      check("stall A mode", m0, A_MODE);
      stall_err = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!wt_valid || wt_seg !== s0 || wt_mode !== m0 || wt_rd_en) stall_err++;
      end
      check("stall hold errors", stall_err, 0);
      wt_ready = 1'b1;
      @(negedge clk);
      wt_ready = 1'b0;
      check("stall one transfer", {wt_valid, wt_mode}, {1'b0, B_MODE});
      wait_valid("stall B", 40);
      check("stall B data", wt_seg, exp_seg_of(209, 6));
      check("stall B mode", wt_mode, B_MODE);
      wt_ready = 1'b1;
      c = 0;
      while (!done && c < 60) begin
         @(negedge clk);
         c++;
      end
      check("stall run done", done, 1'b1);
      @(negedge clk);
   endtask

   task automatic reset_seq();
      int err;
      @(negedge clk);
      start = 1'b1; kernel_mode = 1'b0; base_addr = 9'd0; num_kernels = 9'd1; wt_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset in fetch", {wt_rd_en, dbg_state}, {1'b1, 3'(FETCH)});
      rst_n = 1'b0;
      #1;
      check("mid-fetch reset outputs",
            {busy, done, wt_rd_en, wt_rd_addr, wt_seg, wt_mode, wt_valid, dbg_state}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      err = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || wt_valid || wt_rd_en || busy) err++;
      end
      check("post-reset quiet", err, 0);
   endtask

   initial begin
      vecs[0] = '{km: 1'b0, base: 0,   nk: 1, glitch: 1'b0, exp_valid: 11, exp_done: 12, exp_segs: 1, exp_reads: 9};
      vecs[1] = '{km: 1'b1, base: 100, nk: 2, glitch: 1'b0, exp_valid: 11, exp_done: 67, exp_segs: 8, exp_reads: 50};
      vecs[2] = '{km: 1'b1, base: 500, nk: 1, glitch: 1'b0, exp_valid: 11, exp_done: 34, exp_segs: 4, exp_reads: 25};
      vecs[3] = '{km: 1'b0, base: 505, nk: 3, glitch: 1'b0, exp_valid: 11, exp_done: 34, exp_segs: 3, exp_reads: 27};
      vecs[4] = '{km: 1'b0, base: 0,   nk: 0, glitch: 1'b0, exp_valid: -1, exp_done: 1,  exp_segs: 0, exp_reads: 0};
      vecs[5] = '{km: 1'b1, base: 10,  nk: 1, glitch: 1'b1, exp_valid: 11, exp_done: 34, exp_segs: 4, exp_reads: 25};

      rst_n = 1'b0; start = 1'b0; kernel_mode = 1'b0; base_addr = '0;
      num_kernels = '0; wt_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset state",
            {busy, done, wt_rd_en, wt_rd_addr, wt_seg, wt_mode, wt_valid, dbg_state}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i);
      stall_seq();
      reset_seq();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
